// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: accepts one LD/SD request at a time and answers
// after a fixed latency with the pre-write word, flagging illegal accesses.
module dbus_sram_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        dresp_err
);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [IDX_W+2:0] addr;
    logic [2:0]       size;
    logic [7:0]       strobe;
    logic [63:0]      data;
  } req_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] mem_q [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;

  // Address bits above the array index wrap away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dreq_addr[63:IDX_W+3];

  function automatic logic is_legal(input logic [2:0] addr, input logic [2:0] size);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return addr[0] == 1'b0;
      3'd2:    return addr[1:0] == 2'b00;
      3'd3:    return addr[2:0] == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (dreq_valid) begin
          req_d = '{addr:   dreq_addr[IDX_W+2:0],
                    size:   dreq_size,
                    strobe: dreq_strobe,
                    data:   dreq_data};
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // req_d already holds the request being answered, even when IDLE jumps straight to RESP.
    if (state_d == RESP && state_q != RESP) begin
      rdata_d = is_legal(req_d.addr[2:0], req_d.size) ? mem_q[req_d.addr[IDX_W+2:3]] : 64'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  assign wr_idx = req_q.addr[IDX_W+2:3];
  assign wr_en  = (state_q == RESP) && !reset && (req_q.strobe != 8'd0)
                  && is_legal(req_q.addr[2:0], req_q.size);

  // NOTE: the array is deliberately not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (req_q.strobe[i]) mem_q[wr_idx][8*i +: 8] <= req_q.data[8*i +: 8];
      end
    end
  end

  assign dresp_addr_ok = (state_q == RESP);
  assign dresp_data_ok = (state_q == RESP);
  assign dresp_err     = (state_q == RESP) && !is_legal(req_q.addr[2:0], req_q.size);
  assign dresp_data    = rdata_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: a word-level memory model predicts
// each response, and a negedge monitor compares whatever the DUT presents.
module tb_dbus_sram_responder;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 2;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        dresp_err;

  dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .dresp_err     (dresp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [int];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ok_prev  = -1;
  int          ok_last  = -1;
  bit          mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) % 64'(DEPTH));
  endfunction

  function automatic bit legal(input logic [63:0] a, input logic [2:0] s);
    if (s > 3'd3) return 1'b0;
    return (a % (64'd1 << s)) == 64'd0;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 right after the response.
  task automatic do_req(input logic [63:0] a, input logic [2:0] s,
                        input logic [7:0] st, input logic [63:0] d);
    exp_t        e;
    int          w;
    logic [63:0] word;
    bit          got;
    w    = word_of(a);
    word = model_mem.exists(w) ? model_mem[w] : 64'd0;
    if (legal(a, s)) begin
      e.data = word;
      e.err  = 1'b0;
      for (int i = 0; i < 8; i++) if (st[i]) word[8*i +: 8] = d[8*i +: 8];
      model_mem[w] = word;
    end else begin
      e.data = 64'd0;
      e.err  = 1'b1;
    end
    e.issue = cyc;
    exp_q.push_back(e);
    dreq_addr   = a;
    dreq_size   = s;
    dreq_strobe = st;
    dreq_data   = d;
    dreq_valid  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      @(negedge clk);
      got = dresp_data_ok;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: no data_ok within %0d cycles for addr 0x%0h", BUDGET, a);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    dreq_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (dresp_data_ok) begin
        ok_prev = ok_last;
        ok_last = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_data_ok: got data_ok=1 expected no response at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", dresp_data, e.data);
          check("resp_err", 64'(dresp_err), 64'(e.err));
          check("resp_addr_ok", 64'(dresp_addr_ok), 64'd1);
          check("resp_latency", 64'(cyc - e.issue), 64'(LAT));
        end
      end else begin
        check("idle_addr_ok", 64'(dresp_addr_ok), 64'd0);
        check("idle_err", 64'(dresp_err), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    logic [63:0] a;
    logic [2:0]  s;
    logic [7:0]  st;
    logic [2:0]  off;

    reset       = 1'b1;
    dreq_valid  = 1'b0;
    dreq_addr   = 64'd0;
    dreq_size   = 3'd0;
    dreq_strobe = 8'd0;
    dreq_data   = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr_ok", 64'(dresp_addr_ok), 64'd0);
    check("rst_data_ok", 64'(dresp_data_ok), 64'd0);
    check("rst_err", 64'(dresp_err), 64'd0);
    check("rst_data", dresp_data, 64'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed cases: zero read, full write, byte merge, illegal accesses, wrap.
    do_req(64'h80, 3'd3, 8'h00, 64'd0);
    do_req(64'h10, 3'd3, 8'hFF, 64'h1122334455667788);
    do_req(64'h10, 3'd3, 8'h00, 64'd0);
    do_req(64'h13, 3'd0, 8'h08, 64'h00000000AB000000);
    do_req(64'h10, 3'd3, 8'h00, 64'd0);
    do_req(64'h12, 3'd2, 8'hF0, 64'hDEADBEEFCAFEF00D);
    do_req(64'h10, 3'd3, 8'h00, 64'd0);
    do_req(64'h10, 3'd5, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
    do_req(64'h10, 3'd3, 8'h00, 64'd0);
    do_req(64'h2008, 3'd3, 8'hFF, 64'hA5A55A5A0F0FF0F0);
    do_req(64'h0008, 3'd3, 8'h00, 64'd0);

    // Reset lands while a write to 0x40 sits in WAIT; the write must vanish.
    do_req(64'h40, 3'd3, 8'hFF, 64'h0123456789ABCDEF);
    dreq_addr   = 64'h40;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data   = 64'hFEEDFACEFEEDFACE;
    dreq_valid  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    dreq_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_data_ok", 64'(dresp_data_ok), 64'd0);
    check("mid_rst_data", dresp_data, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Two back-to-back reads: data_ok pulses LATENCY+1 cycles apart.
    do_req(64'h40, 3'd3, 8'h00, 64'd0);
    do_req(64'h10, 3'd3, 8'h00, 64'd0);
    check("b2b_spacing", 64'(ok_last - ok_prev), 64'(LAT + 1));

    // Randomized traffic over a small window with random high bits to exercise wrap.
    for (int n = 0; n < 300; n++) begin
      s   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7));
      if (s <= 3'd3 && $urandom_range(0, 3) != 0) off = off & ~3'((4'd1 << s) - 4'd1);
      a   = {$urandom, $urandom};
      a[12:0] = {7'($urandom_range(0, 31)), 3'd0, off} & 13'h1FFF;
      a[12:3] = 10'($urandom_range(0, 31));
      a[2:0]  = off;
      st  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
      do_req(a, s, st, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
